// File: rtl/reg_writeback.sv
// Register-file write-back stage: merges immediate ALU writes with a buffered load-return FIFO
// under starvation-bounded arbitration. Optional macro REG_WRITEBACK_FWD_EN adds a write-bypass port.
module reg_writeback #(
    parameter int DATA_WIDTH    = 32,
    parameter int REGFILE_WIDTH = 4,
    parameter int LDQ_DEPTH     = 4,
    parameter int STARVE_MAX    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [REGFILE_WIDTH-1:0]   alu_addr,
    input  logic [DATA_WIDTH-1:0]      alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [REGFILE_WIDTH-1:0]   ld_addr,
    input  logic [DATA_WIDTH-1:0]      ld_data,
    input  logic [REGFILE_WIDTH-1:0]   chk_addr,
    output logic                       chk_hit,
`ifdef REG_WRITEBACK_FWD_EN
    input  logic [REGFILE_WIDTH-1:0]   fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_WIDTH-1:0]      fwd_data,
`endif
    output logic                       WEN,
    output logic [REGFILE_WIDTH-1:0]   WADD,
    output logic [DATA_WIDTH-1:0]      WDAT,
    output logic [$clog2(LDQ_DEPTH):0] ldq_count
);

    localparam int PTR_W    = $clog2(LDQ_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic {
        FAIR,
        DRAIN
    } state_e;

    state_e                     state_q, state_d;
    logic [STARVE_W-1:0]        starve_q, starve_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [LDQ_DEPTH-1:0]       vld_q, vld_d;
    logic [REGFILE_WIDTH-1:0]   addr_mem_q [LDQ_DEPTH];
    logic [DATA_WIDTH-1:0]      data_mem_q [LDQ_DEPTH];
    logic                       wen_q, wen_d;
    logic [REGFILE_WIDTH-1:0]   wadd_q, wadd_d;
    logic [DATA_WIDTH-1:0]      wdat_q, wdat_d;

    logic push;
    logic pop;
    logic alu_fire;
    logic fifo_nonempty;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_ready     = (state_q == FAIR);
        ld_ready      = (count_q < CNT_W'(LDQ_DEPTH));
        alu_fire      = alu_valid && alu_ready;
        push          = ld_valid && ld_ready;
        fifo_nonempty = (count_q != '0);
        pop           = 1'b0;
        wen_d         = 1'b0;
        wadd_d        = wadd_q;
        wdat_d        = wdat_q;
        starve_d      = starve_q;

        case (state_q)
            FAIR: begin
                if (alu_fire) begin
                    wen_d  = 1'b1;
                    wadd_d = alu_addr;
                    wdat_d = alu_data;
                    if (fifo_nonempty) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (fifo_nonempty) begin
                    pop = 1'b1;
                end
            end
            DRAIN: begin
                // The ALU is held off, so the head always goes this cycle.
                pop = fifo_nonempty;
            end
            default: pop = 1'b0;
        endcase

        if (pop) begin
            wen_d    = 1'b1;
            wadd_d   = addr_mem_q[rd_ptr_q];
            wdat_d   = data_mem_q[rd_ptr_q];
            starve_d = '0;
        end

        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);

        vld_d = vld_q;
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
        end

        if (count_d == '0) begin
            starve_d = '0;
        end
        state_d = (starve_d == STARVE_W'(STARVE_MAX)) ? DRAIN : FAIR;
    end

    // Scoreboard: any queued load or the write in flight on the port.
    always_comb begin
        chk_hit = wen_q && (wadd_q == chk_addr);
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            if (vld_q[i] && (addr_mem_q[i] == chk_addr)) begin
                chk_hit = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FAIR;
            starve_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            wen_q    <= 1'b0;
            wadd_q   <= '0;
            wdat_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            wen_q    <= wen_d;
            wadd_q   <= wadd_d;
            wdat_q   <= wdat_d;
        end
    end

    // NOTE: the payload storage is not reset; vld_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= ld_addr;
            data_mem_q[wr_ptr_q] <= ld_data;
        end
    end

    assign WEN       = wen_q;
    assign WADD      = wadd_q;
    assign WDAT      = wdat_q;
    assign ldq_count = count_q;

`ifdef REG_WRITEBACK_FWD_EN
    assign fwd_hit  = wen_q && (wadd_q == fwd_addr);
    assign fwd_data = wdat_q;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the write-back rules.
module tb_reg_writeback;

    localparam int DW         = 32;
    localparam int AW         = 4;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    logic          clk;
    logic          rst;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [AW-1:0] chk_addr;
    logic          chk_hit;
    logic          WEN;
    logic [AW-1:0] WADD;
    logic [DW-1:0] WDAT;
    logic [2:0]    ldq_count;
`ifdef REG_WRITEBACK_FWD_EN
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
`endif

    reg_writeback #(
        .DATA_WIDTH   (DW),
        .REGFILE_WIDTH(AW),
        .LDQ_DEPTH    (DEPTH),
        .STARVE_MAX   (STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_addr (alu_addr),
        .alu_data (alu_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .chk_addr (chk_addr),
        .chk_hit  (chk_hit),
`ifdef REG_WRITEBACK_FWD_EN
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
`endif
        .WEN      (WEN),
        .WADD     (WADD),
        .WDAT     (WDAT),
        .ldq_count(ldq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural reference: a queue of pending loads, a starvation counter and the port contents.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ld_t;

    ld_t           mq[$];
    int            m_starve;
    logic          m_wen;
    logic [AW-1:0] m_wadd;
    logic [DW-1:0] m_wdat;

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_wen    = 1'b0;
        m_wadd   = '0;
        m_wdat   = '0;
    endtask

    function automatic logic model_hit(input logic [AW-1:0] a);
        foreach (mq[i]) begin
            if (mq[i].addr == a) return 1'b1;
        end
        return m_wen && (m_wadd == a);
    endfunction

    // One clock cycle: starts just after a falling edge, ends on the next falling edge.
    task automatic cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                         input logic [AW-1:0] ca);
        logic exp_alu_ready;
        logic exp_ld_ready;
        logic nonempty;
        ld_t  head;

        check("WEN", 32'(WEN), 32'(m_wen));
        check("WADD", 32'(WADD), 32'(m_wadd));
        check("WDAT", WDAT, m_wdat);
        check("ldq_count", 32'(ldq_count), 32'(mq.size()));

        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        ld_valid  = lv;
        ld_addr   = la;
        ld_data   = ld;
        chk_addr  = ca;
        #1;

        exp_alu_ready = (m_starve < STARVE_MAX);
        exp_ld_ready  = (mq.size() < DEPTH);
        check("alu_ready", 32'(alu_ready), 32'(exp_alu_ready));
        check("ld_ready", 32'(ld_ready), 32'(exp_ld_ready));
        check("chk_hit", 32'(chk_hit), 32'(model_hit(ca)));

        nonempty = (mq.size() > 0);
        if (av && exp_alu_ready) begin
            m_wen  = 1'b1;
            m_wadd = aa;
            m_wdat = ad;
            if (nonempty) m_starve++;
        end else if (nonempty) begin
            head     = mq.pop_front();
            m_wen    = 1'b1;
            m_wadd   = head.addr;
            m_wdat   = head.data;
            m_starve = 0;
        end else begin
            m_wen = 1'b0;
        end
        if (lv && exp_ld_ready) mq.push_back('{addr: la, data: ld});
        if (mq.size() == 0) m_starve = 0;

        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, 4'hF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] seen[$];
        int            drain_cycles;
        int            stale_writes;
        logic [AW-1:0] rst_chk [3];

        rst       = 1'b0;
        alu_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        chk_addr  = '0;
`ifdef REG_WRITEBACK_FWD_EN
        fwd_addr  = '0;
`endif
        model_reset();

        // Reset state
        rst_chk = '{4'd0, 4'd5, 4'd15};
        foreach (rst_chk[i]) begin
            chk_addr = rst_chk[i];
            #1;
            check("reset chk_hit", 32'(chk_hit), 32'd0);
        end
        check("reset WEN", 32'(WEN), 32'd0);
        check("reset WADD", 32'(WADD), 32'd0);
        check("reset WDAT", WDAT, 32'd0);
        check("reset ldq_count", 32'(ldq_count), 32'd0);
        check("reset alu_ready", 32'(alu_ready), 32'd1);
        check("reset ld_ready", 32'(ld_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Single ALU write: one-cycle latency, single-cycle pulse
        cycle(1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 4'hF);
        check("alu WEN", 32'(WEN), 32'd1);
        check("alu WADD", 32'(WADD), 32'd5);
        check("alu WDAT", WDAT, 32'hDEAD_BEEF);
        idle(1);
        check("alu WEN pulse", 32'(WEN), 32'd0);

        // Single load: written two cycles later, scoreboard hit while queued and while writing
        cycle(1'b0, '0, '0, 1'b1, 4'd3, 32'h1234_5678, 4'd3);
        check("ld queued chk_hit", 32'(chk_hit), 32'd1);
        check("ld queued WEN", 32'(WEN), 32'd0);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 4'd3);
        check("ld WEN", 32'(WEN), 32'd1);
        check("ld WADD", 32'(WADD), 32'd3);
        check("ld WDAT", WDAT, 32'h1234_5678);
        check("ld writing chk_hit", 32'(chk_hit), 32'd1);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 4'd3);
        check("ld done chk_hit", 32'(chk_hit), 32'd0);
        check("ld done WEN", 32'(WEN), 32'd0);

        // Fill the FIFO under continuous ALU traffic, then watch the drain pattern
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 4'd14, $urandom, 1'b1, AW'(8 + i), $urandom, 4'd8);
        end
        check("full ldq_count", 32'(ldq_count), 32'd4);
        check("full ld_ready", 32'(ld_ready), 32'd0);
        check("full alu_ready", 32'(alu_ready), 32'd0);
        drain_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (!alu_ready) drain_cycles++;
            cycle(1'b1, 4'd14, $urandom, 1'b1, 4'd1, $urandom, 4'd8);
            if (i == 0) check("drain first load WADD", 32'(WADD), 32'd8);
            if (i == 3) begin
                ld_valid = 1'b0;
                // Stop feeding loads once the first drain shows ld_ready reopening.
                for (int j = 0; j < 16; j++) begin
                    if (!alu_ready) drain_cycles++;
                    cycle(1'b1, 4'd14, $urandom, 1'b0, '0, '0, 4'd8);
                end
                break;
            end
        end
        check("drain cycles", 32'(drain_cycles), 32'(4 + 1));
        idle(6);
        check("drained ldq_count", 32'(ldq_count), 32'd0);

        // Simultaneous push and pop at count=2, order preserved across pointer wrap
        seen.delete();
        for (int i = 0; i < 8; i++) begin
            cycle(i < 2, 4'd15, 32'hA100_0000, 1'b1, AW'(i), 32'h1D00_0000 | 32'(i), 4'hE);
            if (WEN && WDAT[31:8] == 24'h1D0000) seen.push_back(WADD);
            if (i >= 1) check("steady ldq_count", 32'(ldq_count), 32'd2);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, '0, 1'b0, '0, '0, 4'hE);
            if (WEN && WDAT[31:8] == 24'h1D0000) seen.push_back(WADD);
        end
        check("wrap write count", 32'(seen.size()), 32'd8);
        foreach (seen[i]) check("wrap order", 32'(seen[i]), 32'(i));

        // Asynchronous reset with three loads queued
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'd2, $urandom, 1'b1, 4'd9, $urandom, 4'd9);
        end
        check("pre-reset ldq_count", 32'(ldq_count), 32'd3);
        check("pre-reset WEN", 32'(WEN), 32'd1);
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async rst WEN", 32'(WEN), 32'd0);
        check("async rst ldq_count", 32'(ldq_count), 32'd0);
        check("async rst chk_hit", 32'(chk_hit), 32'd0);
        check("async rst alu_ready", 32'(alu_ready), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        stale_writes = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, '0, '0, 1'b0, '0, '0, 4'd9);
            if (WEN) stale_writes++;
        end
        check("stale writes after reset", 32'(stale_writes), 32'd0);

`ifdef REG_WRITEBACK_FWD_EN
        fwd_addr = 4'd7;
        cycle(1'b1, 4'd7, 32'hA5A5_A5A5, 1'b0, '0, '0, 4'hF);
        check("fwd_hit match", 32'(fwd_hit), 32'd1);
        check("fwd_data", fwd_data, 32'hA5A5_A5A5);
        fwd_addr = 4'd6;
        #1;
        check("fwd_hit other", 32'(fwd_hit), 32'd0);
        idle(1);
`endif

        // Randomized traffic at several ALU loads
        foreach (rst_chk[p]) begin
            int alu_pct;
            alu_pct = (p == 0) ? 20 : (p == 1) ? 60 : 95;
            for (int i = 0; i < 500; i++) begin
                cycle($urandom_range(0, 99) < alu_pct, AW'($urandom), $urandom,
                      $urandom_range(0, 99) < 50, AW'($urandom), $urandom, AW'($urandom));
            end
        end
        idle(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back stage that sits directly upstream of the register file and drives its single write port (WADD/WDAT/WEN). It merges ALU results, which are written immediately, with load-return data from memory, which is buffered in a 4-entry FIFO. A starvation counter arbitrates between the two sources. The stage also gives the issue logic a pending-load scoreboard lookup so it can avoid read-after-write and write-after-write hazards on registers with outstanding loads.

## Interface
- DATA_WIDTH, 32, register data width
- REGFILE_WIDTH, 4, register address width
- LDQ_DEPTH, 4, load FIFO depth (power of two)
- STARVE_MAX, 3, consecutive ALU-won cycles allowed while a load is pending
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- alu_valid  input  1  ALU write request
- alu_ready  output  1  ALU request accepted this cycle
- alu_addr  input  REGFILE_WIDTH  ALU destination register
- alu_data  input  DATA_WIDTH  ALU result
- ld_valid  input  1  load-return request
- ld_ready  output  1  load FIFO can accept
- ld_addr  input  REGFILE_WIDTH  load destination register
- ld_data  input  DATA_WIDTH  loaded word
- chk_addr  input  REGFILE_WIDTH  scoreboard query address
- chk_hit  output  1  a queued or in-flight load targets chk_addr
- WEN  output  1  register-file write enable
- WADD  output  REGFILE_WIDTH  register-file write address
- WDAT  output  DATA_WIDTH  register-file write data
- ldq_count  output  3  current FIFO occupancy (0..4)

## Operation
- **ALU path**
  - A transfer occurs when alu_valid && alu_ready.
  - It registers alu_addr/alu_data onto WADD/WDAT with WEN=1 on the next cycle.
  - No buffering on this path.
- **Load path**
  - A transfer occurs when ld_valid && ld_ready.
  - The entry is pushed at the FIFO tail.
  - ld_ready = (count < LDQ_DEPTH). When full, ld_ready is 0 even if a pop occurs in the same cycle.
- **Arbitration:** per cycle, at most one source owns the output register.
  - If alu_valid && alu_ready, the ALU wins. If the FIFO is non-empty, starve_cnt increments.
  - Otherwise, if the FIFO is non-empty, the head is popped to WADD/WDAT, WEN=1, and starve_cnt clears.
  - Otherwise WEN=0; WADD and WDAT hold their previous values.
- **Starvation FSM**
  - States: FAIR (starve_cnt < STARVE_MAX) and DRAIN (starve_cnt == STARVE_MAX).
  - In DRAIN: alu_ready=0 and the FIFO head pops unconditionally, then the FSM returns to FAIR.
  - In FAIR: alu_ready=1.
  - When the FIFO becomes empty, starve_cnt clears.
- **Simultaneous push and pop:** legal when not full. Count is unchanged; pointers both advance and wrap modulo LDQ_DEPTH.
- **Push into an empty FIFO:** the entry cannot pop in the same cycle (no flow-through).
- **Scoreboard**
  - chk_hit is the combinational OR over valid FIFO entries with addr == chk_addr, plus (WEN && WADD == chk_addr).
  - Upstream must not issue an ALU write to a register while chk_hit is 1. The block does not reorder or detect WAW conflicts.
- **Reset (rst=0, asynchronous)**
  - WEN=0, WADD=0, WDAT=0; FIFO empty, ldq_count=0; starve_cnt=0, state FAIR.
  - alu_ready=1, ld_ready=1, chk_hit=0 (for any chk_addr).
  - Reset during operation discards queued loads.

## Timing
- ALU latency: request in cycle N → WEN=1 in cycle N+1.
- Load latency, uncontended: push in cycle N → pop decision in N+1 → WEN=1 in N+2.
- Worst-case wait of a load at the FIFO head under continuous ALU traffic: STARVE_MAX+1 cycles.
- WEN is a single-cycle pulse per write. Back-to-back writes occur on consecutive cycles.
- All outputs are registered except alu_ready, ld_ready, and chk_hit, which are combinational from state and inputs.

## Configuration
- **REG_WRITEBACK_FWD_EN defined**
  - Adds ports: fwd_addr input (REGFILE_WIDTH), fwd_hit output (1), fwd_data output (DATA_WIDTH).
  - fwd_hit = WEN && (WADD == fwd_addr); fwd_data = WDAT.
  - This lets operand reads bypass a register-file write in the same cycle.
- **Undefined:** the ports are absent and there is no compare logic.

## Test plan
- Reset mid-traffic with 3 loads queued, rst=0 → WEN=0, ldq_count=0, chk_hit=0 immediately (asynchronous); after release, no stale writes.
- Single ALU write: addr=5, data=0xDEADBEEF in cycle 10 → WEN=1, WADD=5, WDAT=0xDEADBEEF in cycle 11 only.
- Single load: addr=3, data=0x12345678 in cycle 10, no ALU traffic → WEN=1, WADD=3 in cycle 12; chk_addr=3 gives chk_hit=1 in cycles 11–12.
- Fill FIFO with 4 loads under a continuous alu_valid stream:
  - ld_ready=0 at count=4.
  - After 3 ALU writes, alu_ready=0 for one cycle and load 0 is written.
  - Pattern repeats until the FIFO is empty.
- Push and pop in the same cycle at count=2 → count stays 2, FIFO order is preserved across the pointer wrap (8 loads total, written in order with addrs 0–7).
- With REG_WRITEBACK_FWD_EN: ALU write to r7=0xA5A5A5A5, fwd_addr=7 → fwd_hit=1, fwd_data=0xA5A5A5A5 in the WEN cycle; fwd_addr=6 → fwd_hit=0.
